// File: rtl/fft_host_param.sv
// fft_host_param: N-point in-place radix-2 add/sub butterfly engine with XOR payload mix
//
// Loads an N-point complex frame over a valid/ready stream, runs LOG2N butterfly stages
// (wrap, scaled, bypass or saturate arithmetic), XORs aux_y into every sample, then
// streams the frame back out.
//
// Ports:
//   clk, rst (sync, active low)
//   mode[1:0]                 frame mode, captured on the first input beat
//   in_valid/in_ready         input handshake; in_ready only while loading
//   in_real/in_imag           input sample
//   out_valid/out_ready       output handshake
//   out_real/out_imag         output sample; out_last marks beat N-1
//   busy                      frame in progress
//   overflow                  sticky per frame arithmetic overflow/clamp
//   aux_a..aux_e              generator bytes gen[47:8]
//   aux_mode                  latched frame mode
//   aux_y                     payload XORed into every sample during the mix pass
module fft_host_param #(
    parameter int N_POINTS = 8,
    parameter int LOG2N    = 3,
    parameter int DATA_W   = 16,
    parameter int GEN_W    = 160,
    parameter logic [GEN_W-1:0] GEN_SEED = GEN_W'(160'h123456789ABCDEF0123456789ABCDEF012345678)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              out_last,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        aux_a,
    output logic [7:0]        aux_b,
    output logic [7:0]        aux_c,
    output logic [7:0]        aux_d,
    output logic [7:0]        aux_e,
    output logic [1:0]        aux_mode,
    input  logic [15:0]       aux_y
);
    localparam int CW = LOG2N;

    typedef enum logic [1:0] {S_LOAD, S_STAGE, S_MIX, S_UNLOAD} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt, r_stage;
    logic [1:0]        r_mode;
    logic              r_ovf;
    logic              r_out_valid, r_out_last;
    logic [DATA_W-1:0] r_out_re, r_out_im;
    logic [GEN_W-1:0]  r_gen;
    logic [DATA_W-1:0] r_re [N_POINTS];
    logic [DATA_W-1:0] r_im [N_POINTS];

    logic              w_accept, w_busy, w_cnt_last, w_bf_last, w_st_last, w_out_done;
    logic [1:0]        w_mode;
    logic [CW-1:0]     w_ld_addr, w_span, w_i, w_j;
    logic [DATA_W-1:0] w_y;
    logic [DATA_W:0]   w_re_sum, w_re_dif, w_im_sum, w_im_dif;

    function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] k);
        for (int b = 0; b < CW; b++) bitrev[b] = k[CW-1-b];
    endfunction

    // Returns {overflow, result}; sum/difference is formed one bit wider, then wrapped,
    // halved or clamped depending on mode.
    function automatic logic [DATA_W:0] bfly(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic sub, input logic [1:0] m);
        logic [DATA_W:0] s;
        logic            ov;
        s  = sub ? {a[DATA_W-1], a} - {b[DATA_W-1], b} : {a[DATA_W-1], a} + {b[DATA_W-1], b};
        ov = s[DATA_W] ^ s[DATA_W-1];
        return {ov && m != 2'd1,
                m == 2'd1 ? s[DATA_W:1] :
                (m == 2'd3 && ov) ? {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}} : s[DATA_W-1:0]};
    endfunction

    assign w_accept   = in_valid && r_state == S_LOAD;
    assign w_busy     = r_state != S_LOAD || r_cnt != '0;
    assign w_cnt_last = r_cnt == CW'(N_POINTS-1);
    assign w_bf_last  = r_cnt == CW'(N_POINTS/2-1);
    assign w_st_last  = r_stage == CW'(LOG2N-1);
    assign w_out_done = r_out_valid && out_ready && r_out_last;
    assign w_mode     = r_cnt == '0 ? mode : r_mode;
    assign w_ld_addr  = w_mode == 2'd2 ? r_cnt : bitrev(r_cnt);
    assign w_y        = DATA_W'(aux_y);
    // Butterfly p of stage s pairs i=(p>>s)*2^(s+1)+(p mod 2^s) with j=i+2^s.
    assign w_span     = CW'(1) << r_stage;
    assign w_i        = ((r_cnt >> r_stage) << (r_stage + CW'(1))) | (r_cnt & (w_span - CW'(1)));
    assign w_j        = w_i | w_span;
    assign w_re_sum   = bfly(r_re[w_i], r_re[w_j], 1'b0, r_mode);
    assign w_re_dif   = bfly(r_re[w_i], r_re[w_j], 1'b1, r_mode);
    assign w_im_sum   = bfly(r_im[w_i], r_im[w_j], 1'b0, r_mode);
    assign w_im_dif   = bfly(r_im[w_i], r_im[w_j], 1'b1, r_mode);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:   if (w_accept && w_cnt_last) w_next = r_mode == 2'd2 ? S_MIX : S_STAGE;
            S_STAGE:  if (w_bf_last && w_st_last) w_next = S_MIX;
            S_MIX:    if (w_cnt_last) w_next = S_UNLOAD;
            S_UNLOAD: if (w_out_done) w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_LOAD;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_stage     <= '0;
            r_mode      <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_gen       <= GEN_SEED;
            for (int k = 0; k < N_POINTS; k++) begin
                r_re[k] <= '0;
                r_im[k] <= '0;
            end
        end else begin
            if (w_busy || w_accept)
                r_gen <= {r_gen[GEN_W-2:0], r_gen[GEN_W-1] ^ r_gen[GEN_W-33] ^ r_gen[GEN_W-65]};
            case (r_state)
                S_LOAD: if (w_accept) begin
                    if (r_cnt == '0) begin
                        r_mode <= mode;
                        r_ovf  <= 1'b0;
                    end
                    r_re[w_ld_addr] <= in_real;
                    r_im[w_ld_addr] <= in_imag;
                    r_cnt           <= r_cnt + CW'(1);
                end
                S_STAGE: begin
                    r_re[w_i] <= w_re_sum[DATA_W-1:0];
                    r_re[w_j] <= w_re_dif[DATA_W-1:0];
                    r_im[w_i] <= w_im_sum[DATA_W-1:0];
                    r_im[w_j] <= w_im_dif[DATA_W-1:0];
                    if (w_re_sum[DATA_W] || w_re_dif[DATA_W] || w_im_sum[DATA_W] || w_im_dif[DATA_W])
                        r_ovf <= 1'b1;
                    r_cnt <= w_bf_last ? '0 : r_cnt + CW'(1);
                    if (w_bf_last) r_stage <= w_st_last ? '0 : r_stage + CW'(1);
                end
                S_MIX: begin
                    r_re[r_cnt] <= r_re[r_cnt] ^ w_y;
                    r_im[r_cnt] <= r_im[r_cnt] ^ w_y;
                    r_cnt       <= r_cnt + CW'(1);
                end
                S_UNLOAD: begin
                    // r_cnt tracks the beat currently presented; first cycle only primes beat 0.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_re    <= r_re[r_cnt];
                        r_out_im    <= r_im[r_cnt];
                        r_out_last  <= w_cnt_last;
                    end else if (out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_cnt       <= '0;
                        end else begin
                            r_out_re   <= r_re[r_cnt + CW'(1)];
                            r_out_im   <= r_im[r_cnt + CW'(1)];
                            r_out_last <= r_cnt == CW'(N_POINTS-2);
                            r_cnt      <= r_cnt + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_state == S_LOAD;
    assign out_valid = r_out_valid;
    assign out_real  = r_out_re;
    assign out_imag  = r_out_im;
    assign out_last  = r_out_last;
    assign busy      = w_busy;
    assign overflow  = r_ovf;
    assign aux_mode  = r_mode;
    assign aux_a     = r_gen[47:40];
    assign aux_b     = r_gen[39:32];
    assign aux_c     = r_gen[31:24];
    assign aux_d     = r_gen[23:16];
    assign aux_e     = r_gen[15:8];
endmodule

// File: tb/tb_fft_host_param.sv
// tb_fft_host_param: random and directed frames checked against an arithmetic frame model
module tb_fft_host_param;
    localparam int N = 8;
    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy, overflow;
    logic [15:0] in_real, in_imag, out_real, out_imag, aux_y;
    logic [7:0]  aux_a, aux_b, aux_c, aux_d, aux_e;
    logic [1:0]  aux_mode;

    logic [159:0] seed = 160'h123456789ABCDEF0123456789ABCDEF012345678;
    logic [15:0]  in_re [N];
    logic [15:0]  in_im [N];
    logic [15:0]  m_re [N];
    logic [15:0]  m_im [N];
    bit           m_ovf;
    logic [15:0]  got_re [N];
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    fft_host_param dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .out_last(out_last), .busy(busy),
        .overflow(overflow), .aux_a(aux_a), .aux_b(aux_b), .aux_c(aux_c), .aux_d(aux_d),
        .aux_e(aux_e), .aux_mode(aux_mode), .aux_y(aux_y)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < L; b++) if (((k >> b) & 1) != 0) r |= 1 << (L - 1 - b);
        return r;
    endfunction

    function automatic int fix(input int v, input int md);
        if (md == 1) return v >>> 1;
        if (md == 3) return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
        return ((v + 32768) & 32'hFFFF) - 32768;
    endfunction

    function automatic bit ovf(input int v, input int md);
        return (md == 0 || md == 3) && (v > 32767 || v < -32768);
    endfunction

    task automatic model(input int md, input logic [15:0] y);
        int xr [N];
        int xi [N];
        int a, b, i, j, sp;
        m_ovf = 0;
        for (int k = 0; k < N; k++) begin
            i = md == 2 ? k : brev(k);
            xr[i] = int'($signed(in_re[k]));
            xi[i] = int'($signed(in_im[k]));
        end
        if (md != 2)
            for (int s = 0; s < L; s++) begin
                sp = 1 << s;
                for (int p = 0; p < N / 2; p++) begin
                    i = (p >> s) * 2 * sp + p % sp;
                    j = i + sp;
                    a = xr[i]; b = xr[j];
                    xr[i] = fix(a + b, md); xr[j] = fix(a - b, md);
                    m_ovf |= ovf(a + b, md) | ovf(a - b, md);
                    a = xi[i]; b = xi[j];
                    xi[i] = fix(a + b, md); xi[j] = fix(a - b, md);
                    m_ovf |= ovf(a + b, md) | ovf(a - b, md);
                end
            end
        for (int k = 0; k < N; k++) begin
            m_re[k] = 16'(xr[k]) ^ y;
            m_im[k] = 16'(xi[k]) ^ y;
        end
    endtask

    task automatic load_frame(input int md, input bit chk_gen);
        int t;
        logic [159:0] g;
        for (int k = 0; k < N; k++) begin
            if (!chk_gen && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_real  = in_re[k];
            in_imag  = in_im[k];
            mode     = k == 0 ? 2'(md) : 2'($urandom);
            t = 0;
            while (!in_ready && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            check("load_ready", in_ready, 1'b1);
            @(posedge clk); #1;
            if (k == 0 && chk_gen) begin
                g = {seed[158:0], seed[159] ^ seed[127] ^ seed[95]};
                check("gen_step", {aux_a, aux_b, aux_c, aux_d, aux_e}, g[47:8]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic unload_check(input int md, input int bp, input int hold_at);
        int t, m, hold;
        logic [15:0] pr, pi;
        logic pl, hs;
        t = 0;
        while (!out_valid && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("latency", t, md == 2 ? N + 1 : L * N / 2 + N + 1);
        m = 0; hold = 0; t = 0;
        while (m < N && t < 400) begin
            if (m == hold_at && hold < 5) begin
                out_ready = 1'b0;
                hold++;
            end else out_ready = $urandom_range(99) >= bp;
            pr = out_real; pi = out_imag; pl = out_last;
            hs = out_valid && out_ready;
            check("in_ready_low", in_ready, 1'b0);
            @(posedge clk); #1;
            t++;
            if (hs) begin
                got_re[m] = pr;
                check($sformatf("real[%0d]", m), pr, m_re[m]);
                check($sformatf("imag[%0d]", m), pi, m_im[m]);
                check($sformatf("last[%0d]", m), pl, m == N - 1);
                m++;
            end else if (m < N)
                check("hold_stable", {out_valid, out_real, out_imag, out_last}, {1'b1, pr, pi, pl});
        end
        out_ready = 1'b0;
        check("beats", m, N);
        check("post_valid", out_valid, 1'b0);
        check("post_ready", in_ready, 1'b1);
        check("post_busy", busy, 1'b0);
        check("overflow", overflow, m_ovf);
        check("aux_mode", aux_mode, md);
    endtask

    task automatic run_frame(input int md, input logic [15:0] y, input int bp, input int hold_at,
                             input bit chk_gen);
        model(md, y);
        aux_y = y;
        load_frame(md, chk_gen);
        unload_check(md, bp, hold_at);
    endtask

    initial begin
        int md;
        rst = 1'b0; mode = 0; in_valid = 0; out_ready = 0; in_real = 0; in_imag = 0; aux_y = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out", {out_valid, out_last, out_real, out_imag}, 0);
        check("rst_flags", {busy, overflow, aux_mode}, 0);
        check("rst_aux", {aux_a, aux_b, aux_c, aux_d, aux_e}, seed[47:8]);

        for (int k = 0; k < N; k++) begin in_re[k] = 16'(k); in_im[k] = 0; end
        run_frame(2, 16'h0000, 0, -1, 1'b1);

        for (int k = 0; k < N; k++) begin in_re[k] = 16'h0001; in_im[k] = 0; end
        run_frame(0, 16'h0000, 0, -1, 1'b0);
        check("ones_re0", got_re[0], 16'h0008);
        for (int k = 0; k < N; k++) in_re[k] = k == 0 ? 16'h1000 : 16'h0000;
        run_frame(0, 16'h0000, 0, -1, 1'b0);
        check("impulse_re7", got_re[7], 16'h1000);

        for (int k = 0; k < N; k++) in_re[k] = 16'h4000;
        run_frame(0, 16'h0000, 0, -1, 1'b0);
        check("wrap_ovf", overflow, 1'b1);
        run_frame(3, 16'h0000, 0, -1, 1'b0);
        check("sat_re0", got_re[0], 16'h7FFF);
        check("sat_ovf", overflow, 1'b1);
        run_frame(1, 16'h0000, 0, -1, 1'b0);
        check("scaled_re0", got_re[0], 16'h4000);
        check("scaled_ovf", overflow, 1'b0);

        for (int k = 0; k < N; k++) begin in_re[k] = 0; in_im[k] = 0; end
        run_frame(2, 16'h00FF, 0, -1, 1'b0);
        check("mix_re5", got_re[5], 16'h00FF);

        for (int k = 0; k < N; k++) begin in_re[k] = 16'($urandom); in_im[k] = 16'($urandom); end
        run_frame(0, 16'($urandom), 0, 3, 1'b0);

        for (int f = 0; f < 24; f++) begin
            md = int'($urandom_range(3));
            for (int k = 0; k < N; k++)
                if (f % 2 == 0) begin
                    in_re[k] = 16'($urandom); in_im[k] = 16'($urandom);
                end else begin
                    in_re[k] = 16'(int'($urandom_range(255)) - 128);
                    in_im[k] = 16'(int'($urandom_range(255)) - 128);
                end
            run_frame(md, 16'($urandom), 30, -1, 1'b0);
        end

        for (int k = 0; k < N; k++) begin in_re[k] = 16'h4000; in_im[k] = 0; end
        load_frame(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", busy, 1'b1);
        check("mid_ovf", overflow, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ovf", overflow, 1'b0);
        check("abort_aux_a", aux_a, seed[47:40]);
        for (int k = 0; k < N; k++) begin in_re[k] = 16'($urandom); in_im[k] = 16'($urandom); end
        run_frame(3, 16'h5A5A, 0, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
